fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the 5-stage core; successor of the fixed two-source EXE/MEM forwarder.
//  Keeps its own shadow pipeline of in-flight writers (dest, wb_en, is_load) and forwards from any of DEPTH stages.
//  Stalls ID on load-use, freezes on memory wait, and counts stall cycles.
//  Sits beside ID; outputs feed the ID/EXE operand registers.
// PARAMETERS
//  DATA_W      32  operand/result width
//  RA_W        5   register address width; register 0 is hard-wired zero
//  DEPTH       3   tracked writer stages (entry 0 = EXE ... DEPTH-1 = WB), 1..8
//  LOAD_READY  1   first entry index at which load data is valid on stage_data
//  CNT_W       16  stall counter width
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  id_valid     in   1           ID holds a real instruction
//  id_src1      in   RA_W        source register 1
//  id_src2      in   RA_W        source register 2
//  id_src1_used in   1           src1 read by the ALU
//  id_src2_used in   1           src2 read by the ALU (0 when immediate)
//  id_is_store  in   1           src2 supplies store data
//  id_dest      in   RA_W        destination register
//  id_wb_en     in   1           instruction writes back
//  id_is_load   in   1           instruction is a load
//  rf_rdata1    in   DATA_W      register-file read port 1
//  rf_rdata2    in   DATA_W      register-file read port 2
//  stage_data   in   DEPTH*DATA_W  result of entry k on bits [k*DATA_W +: DATA_W]
//  mem_wait     in   1           data memory busy; whole pipe frozen
//  flush        in   1           kill instruction in ID (taken branch)
//  op1_out      out  DATA_W      resolved operand 1
//  op2_out      out  DATA_W      resolved operand 2
//  st_data_out  out  DATA_W      resolved store data
//  fwd_hit1     out  1           op1_out forwarded
//  fwd_hit2     out  1           op2_out forwarded
//  stall        out  1           hold PC and IF/ID
//  stall_cnt    out  CNT_W       saturating count of stall cycles
// BEHAVIOUR
//  Reset: all entries invalid, stall_cnt=0.
//   Outputs are then op1_out=rf_rdata1, op2_out=rf_rdata2, st_data_out=rf_rdata2, fwd_hit*=0, stall=mem_wait.
//  Match(src,k): entry[k].valid & wb_en & dest!=0 & dest==src.
//   Youngest (lowest k) match wins; src==0 never forwards.
//  Ready(k): !entry[k].is_load | k>=LOAD_READY.
//  op1: src1_used & match -> stage_data[k], fwd_hit1=1; otherwise rf_rdata1.
//  op2: src2_used & match -> stage_data[k], fwd_hit2=1; otherwise rf_rdata2.
//  st_data: id_is_store & match(src2) -> stage_data[k], independent of src2_used; otherwise rf_rdata2.
//  load_use = id_valid & !flush & (any used operand's winning match is !Ready).
//  stall = load_use | mem_wait. All outputs are combinational from state and inputs: 0-cycle latency.
//  Shift, every clk with mem_wait=0:
//   entry[k] <= entry[k-1] for k>=1.
//   entry[0] <= {1,id_dest,id_wb_en,id_is_load} if id_valid & !flush & !load_use; otherwise bubble (valid=0).
//  mem_wait=1: all entries hold; stall=1 regardless of hazards.
//  flush & load_use in the same cycle: flush wins; no stall; bubble inserted.
//  stall_cnt += 1 on every cycle with stall=1; it saturates at all-ones and never wraps.
//  Async rst mid-operation clears entries and counter immediately; the shadow pipe is empty afterwards.
// STRUCTURE
//  Shared package fwd_pkg:
//   entry field widths and layout, REG_ZERO constant, FWD_NONE select code.
//  Sub-module fwd_match_mux (DEPTH, RA_W, DATA_W), instantiated 3x (op1, op2, st_data):
//   priority search over entries; returns hit, not_ready, data.
//  Top level holds the shadow register array, stall logic and counter.
// TESTING (DEPTH=3, LOAD_READY=1)
//  1 ALU chain: issue add r3; next cycle sub src1=r3, stage_data[0]=0x11
//    -> op1_out=0x11, fwd_hit1=1, stall=0.
//  2 Priority: r3 in entry0 (0xAA) and entry1 (0xBB), src2=r3 used -> op2_out=0xAA.
//  3 Load-use: lw r5 then add src1=r5 -> stall=1 one cycle, entry0 bubble.
//    Next cycle: op1_out=stage_data[1], stall=0, stall_cnt=1.
//  4 r0/imm/store: writer dest=r0, src1=r0 -> fwd_hit1=0.
//    Store with src2=r4 in entry1 (0x55), src2_used=0 -> st_data_out=0x55, fwd_hit2=0, op2_out=rf_rdata2.
//  5 mem_wait high 3 cycles -> entries frozen, stall=1 each cycle, stall_cnt +3.
//    flush during load_use -> stall=0.
//  6 rst asserted mid-stream -> entries invalid at once, stall_cnt=0.
//    CNT_W=2 with 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: shadow-entry layout,
// the hard-wired zero register and the "no forward" select code.
package fwd_pkg;

    localparam int SEL_W = 4;
    typedef logic [SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 4'hF;
    localparam int       REG_ZERO = 0;

    // Entry layout, LSB first: valid, wb_en, is_load, dest[RA_W-1:0]
    localparam int ENT_VALID    = 0;
    localparam int ENT_WB_EN    = 1;
    localparam int ENT_IS_LOAD  = 2;
    localparam int ENT_DEST_LSB = 3;

    function automatic int entry_w(input int ra_w);
        return ra_w + ENT_DEST_LSB;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side bundle of the forwarding/hazard unit: decode fields, register-file
// and stage results in; resolved operands, stall and stall count out.
interface fwd_hazard_unit_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    logic                    id_valid;
    logic [RA_W-1:0]         id_src1;
    logic [RA_W-1:0]         id_src2;
    logic                    id_src1_used;
    logic                    id_src2_used;
    logic                    id_is_store;
    logic [RA_W-1:0]         id_dest;
    logic                    id_wb_en;
    logic                    id_is_load;
    logic [DATA_W-1:0]       rf_rdata1;
    logic [DATA_W-1:0]       rf_rdata2;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    mem_wait;
    logic                    flush;
    logic [DATA_W-1:0]       op1_out;
    logic [DATA_W-1:0]       op2_out;
    logic [DATA_W-1:0]       st_data_out;
    logic                    fwd_hit1;
    logic                    fwd_hit2;
    logic                    stall;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_is_store, id_dest, id_wb_en, id_is_load,
               rf_rdata1, rf_rdata2, stage_data, mem_wait, flush,
        input  op1_out, op2_out, st_data_out, fwd_hit1, fwd_hit2,
               stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_is_store, id_dest, id_wb_en, id_is_load,
               rf_rdata1, rf_rdata2, stage_data, mem_wait, flush,
        output op1_out, op2_out, st_data_out, fwd_hit1, fwd_hit2,
               stall, stall_cnt
    );
endinterface

// File: rtl/fwd_match_mux.sv
// Priority search of one source register over the shadow writer entries;
// the youngest matching writer supplies the data.
module fwd_match_mux
    import fwd_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int RA_W       = 5,
    parameter int DATA_W     = 32,
    parameter int LOAD_READY = 1
) (
    input  logic [DEPTH*(RA_W+ENT_DEST_LSB)-1:0] entries,
    input  logic [RA_W-1:0]                      src,
    input  logic [DEPTH*DATA_W-1:0]              stage_data,
    output logic                                 hit,
    output logic                                 not_ready,
    output logic [DATA_W-1:0]                    data
);
    localparam int ENTRY_W = entry_w(RA_W);

    fwd_sel_t           sel;
    logic [ENTRY_W-1:0] ent;
    logic [RA_W-1:0]    ent_dest;

    // Walk oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        sel       = FWD_NONE;
        not_ready = 1'b0;
        ent       = '0;
        ent_dest  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ent      = entries[k*ENTRY_W +: ENTRY_W];
            ent_dest = ent[ENT_DEST_LSB +: RA_W];
            if (ent[ENT_VALID] && ent[ENT_WB_EN] &&
                ent_dest != RA_W'(REG_ZERO) && ent_dest == src) begin
                sel       = fwd_sel_t'(k);
                not_ready = ent[ENT_IS_LOAD] && (k < LOAD_READY);
            end
        end
    end

    assign hit = (sel != FWD_NONE);

    always_comb begin
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == fwd_sel_t'(k)) begin
                data = stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit beside ID: tracks in-flight writers in a
// shadow pipe, resolves ID operands, stalls on load-use or memory wait.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RA_W       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_unit_if.slave bus
);
    localparam int ENTRY_W = entry_w(RA_W);

    logic [DEPTH-1:0][ENTRY_W-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

    logic              hit1, hit2, hit_st;
    logic              nr1, nr2, nr_st;
    logic [DATA_W-1:0] fdata1, fdata2, fdata_st;
    logic              load_use;
    logic              stall;

    fwd_match_mux #(.DEPTH(DEPTH), .RA_W(RA_W), .DATA_W(DATA_W), .LOAD_READY(LOAD_READY))
    u_match_op1 (
        .entries   (ent_q),
        .src       (bus.id_src1),
        .stage_data(bus.stage_data),
        .hit       (hit1),
        .not_ready (nr1),
        .data      (fdata1)
    );

    fwd_match_mux #(.DEPTH(DEPTH), .RA_W(RA_W), .DATA_W(DATA_W), .LOAD_READY(LOAD_READY))
    u_match_op2 (
        .entries   (ent_q),
        .src       (bus.id_src2),
        .stage_data(bus.stage_data),
        .hit       (hit2),
        .not_ready (nr2),
        .data      (fdata2)
    );

    fwd_match_mux #(.DEPTH(DEPTH), .RA_W(RA_W), .DATA_W(DATA_W), .LOAD_READY(LOAD_READY))
    u_match_st (
        .entries   (ent_q),
        .src       (bus.id_src2),
        .stage_data(bus.stage_data),
        .hit       (hit_st),
        .not_ready (nr_st),
        .data      (fdata_st)
    );

    // Store data counts as a used operand: a store cannot leave ID with stale data.
    assign load_use = bus.id_valid && !bus.flush &&
                      ((bus.id_src1_used && nr1) ||
                       (bus.id_src2_used && nr2) ||
                       (bus.id_is_store  && nr_st));
    assign stall    = load_use || bus.mem_wait;

    assign bus.fwd_hit1    = bus.id_src1_used && hit1;
    assign bus.fwd_hit2    = bus.id_src2_used && hit2;
    assign bus.op1_out     = bus.fwd_hit1 ? fdata1 : bus.rf_rdata1;
    assign bus.op2_out     = bus.fwd_hit2 ? fdata2 : bus.rf_rdata2;
    assign bus.st_data_out = (bus.id_is_store && hit_st) ? fdata_st : bus.rf_rdata2;
    assign bus.stall       = stall;
    assign bus.stall_cnt   = stall_cnt_q;

    always_comb begin
        ent_d = ent_q;
        if (!bus.mem_wait) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[0] = '0;
            if (bus.id_valid && !bus.flush && !load_use) begin
                ent_d[0][ENT_VALID]             = 1'b1;
                ent_d[0][ENT_WB_EN]             = bus.id_wb_en;
                ent_d[0][ENT_IS_LOAD]           = bus.id_is_load;
                ent_d[0][ENT_DEST_LSB +: RA_W]  = bus.id_dest;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=3, LOAD_READY=1) plus a CNT_W=2
// instance for counter saturation.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int DEPTH  = 3;
    localparam logic [31:0] RF1 = 32'h0000_1234;
    localparam logic [31:0] RF2 = 32'h0000_5678;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(16)) bus ();
    fwd_hazard_unit_if #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(2))  bus2 ();

    fwd_hazard_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_READY(1), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus));

    fwd_hazard_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_READY(1), .CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] s1, input logic s1u,
                         input logic [4:0] s2, input logic s2u, input logic st,
                         input logic [4:0] dst, input logic wb, input logic ld);
        bus.id_valid     = v;
        bus.id_src1      = s1;
        bus.id_src1_used = s1u;
        bus.id_src2      = s2;
        bus.id_src2_used = s2u;
        bus.id_is_store  = st;
        bus.id_dest      = dst;
        bus.id_wb_en     = wb;
        bus.id_is_load   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.rf_rdata1  = RF1;
        bus.rf_rdata2  = RF2;
        bus.stage_data = '0;
        bus.mem_wait   = 1'b0;
        bus.flush      = 1'b0;
        bus2.id_valid = 0; bus2.id_src1 = 0; bus2.id_src2 = 0;
        bus2.id_src1_used = 0; bus2.id_src2_used = 0; bus2.id_is_store = 0;
        bus2.id_dest = 0; bus2.id_wb_en = 0; bus2.id_is_load = 0;
        bus2.rf_rdata1 = 0; bus2.rf_rdata2 = 0; bus2.stage_data = '0;
        bus2.mem_wait = 0; bus2.flush = 0;

        // reset state
        issue(1, 3, 1, 4, 1, 1, 0, 0, 0);
        bus.stage_data = {32'hC, 32'hB, 32'hA};
        #2;
        check("rst_op1", bus.op1_out, RF1);
        check("rst_op2", bus.op2_out, RF2);
        check("rst_st", bus.st_data_out, RF2);
        check("rst_hit1", 32'(bus.fwd_hit1), 0);
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_cnt", 32'(bus.stall_cnt), 0);
        bus.mem_wait = 1'b1;
        #1;
        check("rst_stall_mw", 32'(bus.stall), 1);
        bus.mem_wait = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: ALU chain
        issue(1, 1, 1, 2, 1, 0, 3, 1, 0);
        #1;
        check("t1_nohit", 32'(bus.fwd_hit1), 0);
        tick();
        issue(1, 3, 1, 2, 1, 0, 4, 1, 0);
        bus.stage_data = {32'h0, 32'h0, 32'h11};
        #1;
        check("t1_op1", bus.op1_out, 32'h11);
        check("t1_hit1", 32'(bus.fwd_hit1), 1);
        check("t1_stall", 32'(bus.stall), 0);
        check("t1_op2", bus.op2_out, RF2);
        tick();

        // 2: youngest writer wins; older-only match reaches entry 2
        issue(1, 0, 0, 0, 0, 0, 3, 1, 0);
        tick();
        tick();
        issue(1, 4, 1, 3, 1, 0, 0, 0, 0);
        bus.stage_data = {32'hCC, 32'hBB, 32'hAA};
        #1;
        check("t2_op2", bus.op2_out, 32'hAA);
        check("t2_hit2", 32'(bus.fwd_hit2), 1);
        check("t2_op1_old", bus.op1_out, 32'hCC);
        idle(3);

        // 3: load-use
        issue(1, 0, 0, 0, 0, 0, 5, 1, 1);
        #1;
        check("t3_lw_stall", 32'(bus.stall), 0);
        tick();
        issue(1, 5, 1, 6, 1, 0, 6, 1, 0);
        bus.stage_data = {32'h0, 32'h77, 32'h66};
        #1;
        check("t3_stall", 32'(bus.stall), 1);
        check("t3_cnt0", 32'(bus.stall_cnt), 0);
        tick();
        check("t3_op1", bus.op1_out, 32'h77);
        check("t3_stall_rel", 32'(bus.stall), 0);
        check("t3_cnt1", 32'(bus.stall_cnt), 1);
        check("t3_bubble", 32'(bus.fwd_hit2), 0);
        tick();
        idle(3);

        // 4: r0 never forwards; store data ignores src2_used
        issue(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        issue(1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("t4_r0", 32'(bus.fwd_hit1), 0);
        check("t4_r0_op1", bus.op1_out, RF1);
        tick();
        issue(1, 0, 0, 0, 0, 0, 4, 1, 0);
        tick();
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        issue(1, 1, 1, 4, 0, 1, 0, 0, 0);
        bus.stage_data = {32'h0, 32'h55, 32'h99};
        #1;
        check("t4_st", bus.st_data_out, 32'h55);
        check("t4_hit2", 32'(bus.fwd_hit2), 0);
        check("t4_op2", bus.op2_out, RF2);
        tick();

        // 5: mem_wait freezes entries
        issue(1, 0, 0, 0, 0, 0, 7, 1, 0);
        tick();
        issue(1, 7, 1, 0, 0, 0, 8, 1, 0);
        bus.stage_data = {32'h23, 32'h22, 32'h21};
        bus.mem_wait   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_stall", 32'(bus.stall), 1);
            check("t5_op1", bus.op1_out, 32'h21);
            check("t5_cnt", 32'(bus.stall_cnt), 32'(1 + i));
            tick();
        end
        bus.mem_wait = 1'b0;
        #1;
        check("t5_stall_rel", 32'(bus.stall), 0);
        check("t5_op1_rel", bus.op1_out, 32'h21);
        check("t5_cnt_end", 32'(bus.stall_cnt), 4);
        tick();
        idle(3);

        // 5b: flush beats load-use and inserts a bubble
        issue(1, 0, 0, 0, 0, 0, 5, 1, 1);
        tick();
        issue(1, 5, 1, 0, 0, 0, 9, 1, 0);
        bus.flush = 1'b1;
        #1;
        check("t5_flush_stall", 32'(bus.stall), 0);
        tick();
        bus.flush = 1'b0;
        issue(1, 9, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("t5_flush_bubble", 32'(bus.fwd_hit1), 0);
        check("t5_flush_cnt", 32'(bus.stall_cnt), 4);
        tick();

        // 6: async reset mid-stream
        issue(1, 0, 0, 0, 0, 0, 10, 1, 0);
        tick();
        issue(1, 10, 1, 0, 0, 0, 0, 0, 0);
        bus.stage_data = {32'h0, 32'h0, 32'h3C};
        #1;
        check("t6_pre_hit", 32'(bus.fwd_hit1), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_hit", 32'(bus.fwd_hit1), 0);
        check("t6_rst_op1", bus.op1_out, RF1);
        check("t6_rst_cnt", 32'(bus.stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_empty", 32'(bus.fwd_hit1), 0);

        // 6b: 2-bit counter saturates
        check("t6_cnt2_init", 32'(bus2.stall_cnt), 0);
        bus2.mem_wait = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t6_cnt2", 32'(bus2.stall_cnt), 32'((i > 3) ? 3 : i));
        end
        bus2.mem_wait = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
